// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet-level stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    DROP   = 2'd3
  } demux_state_e;

  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b00;

  // Route code to the lane state a new packet will occupy; unknown codes are discarded.
  function automatic demux_state_e decode_sel(input logic [1:0] code);
    demux_state_e res;
    case (code)
      SEL_A:   res = PASS_A;
      SEL_B:   res = PASS_B;
      default: res = DROP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/demux_out_stage.sv
// One-entry registered output stage for a demux lane; supports load and drain in the same cycle.
module demux_out_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic [N-1:0] x_data,
  output logic         x_valid,
  output logic         x_last,
  input  logic         x_ready,
  output logic         stage_ready
);

  logic [N-1:0] data_r;
  logic         last_r;
  logic         valid_r;

  assign stage_ready = !valid_r || x_ready;
  assign x_data      = data_r;
  assign x_last      = last_r;
  assign x_valid     = valid_r;

  // Stage register: load wins over drain; data/last hold their value while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {N{1'b0}};
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= in_data;
      last_r  <= in_last;
      valid_r <= 1'b1;
    end else if (valid_r && x_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-level 1-to-2 stream demultiplexer with a counted discard lane.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic [1:0]       sel,
  output logic [N-1:0]     a_data,
  output logic             a_valid,
  output logic             a_last,
  input  logic             a_ready,
  output logic [N-1:0]     b_data,
  output logic             b_valid,
  output logic             b_last,
  input  logic             b_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count
);

  demux_state_e     state_r, state_next_s, target_s;
  logic             a_stage_ready_s, b_stage_ready_s;
  logic             accept_s, load_a_s, load_b_s;
  logic             busy_r;
  logic [CNT_W-1:0] drop_count_r;

  // Target lane decode, input-side ready and next-state selection.
  always_comb begin
    target_s     = state_r;
    s_ready      = 1'b1;
    state_next_s = state_r;
    if (state_r == IDLE) begin
      target_s = decode_sel(sel);
    end else begin
      target_s = state_r;
    end
    case (target_s)
      PASS_A:  s_ready = a_stage_ready_s;
      PASS_B:  s_ready = b_stage_ready_s;
      default: s_ready = 1'b1;
    endcase
    if (s_valid && s_ready) begin
      state_next_s = s_last ? IDLE : target_s;
    end else begin
      state_next_s = state_r;
    end
  end

  assign accept_s = s_valid && s_ready;
  assign load_a_s = accept_s && (target_s == PASS_A);
  assign load_b_s = accept_s && (target_s == PASS_B);

  // FSM state register; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Saturating count of beats routed to the discard lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && (target_s == DROP) && (drop_count_r != {CNT_W{1'b1}})) begin
      drop_count_r <= drop_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign busy       = busy_r;
  assign drop_count = drop_count_r;

  demux_out_stage #(.N(N)) u_stage_a (
    .clk         (clk),
    .rst         (rst),
    .load        (load_a_s),
    .in_data     (s_data),
    .in_last     (s_last),
    .x_data      (a_data),
    .x_valid     (a_valid),
    .x_last      (a_last),
    .x_ready     (a_ready),
    .stage_ready (a_stage_ready_s)
  );

  demux_out_stage #(.N(N)) u_stage_b (
    .clk         (clk),
    .rst         (rst),
    .load        (load_b_s),
    .in_data     (s_data),
    .in_last     (s_last),
    .x_data      (b_data),
    .x_valid     (b_valid),
    .x_last      (b_last),
    .x_ready     (b_ready),
    .stage_ready (b_stage_ready_s)
  );

endmodule

// File: doc/stream_demux.md
# stream_demux

Packet-level 1-to-2 stream demultiplexer with a discard lane. It is the steering counterpart to the team's `mux` (2-bit select: `01` → A, `00` → B, other codes → zero lane). One input stream with valid/ready handshake is routed, whole packets at a time, to output A, output B, or a drop sink, according to `sel` sampled on each packet's first beat. Each output has a one-entry registered stage, and dropped beats are counted.

## Interface
- `N`, 16, data width of all stream lanes.
- `CNT_W`, 16, width of the saturating drop counter.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  N  input beat data.
- `s_valid`  in  1  input beat valid.
- `s_last`  in  1  final beat of packet.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `sel`  in  2  route code, sampled only on a packet's first accepted beat: `01` → A, `00` → B, `10`/`11` → drop.
- `a_data`  out  N  lane A data.
- `a_valid`  out  1  lane A valid.
- `a_last`  out  1  lane A last.
- `a_ready`  in  1  lane A ready.
- `b_data`  out  N  lane B data.
- `b_valid`  out  1  lane B valid.
- `b_last`  out  1  lane B last.
- `b_ready`  in  1  lane B ready.
- `busy`  out  1  high while the FSM is mid-packet (not IDLE).
- `drop_count`  out  CNT_W  beats discarded since reset; saturates at all-ones.

## Operation
- FSM states: IDLE, PASS_A, PASS_B, DROP.
- IDLE:
  - Target is decoded from the current `sel` (combinationally).
  - `s_ready` equals that target's stage-ready (`!x_valid || x_ready`); it is 1 for the drop target.
  - On an accepted beat with `s_last=0`, go to PASS_A, PASS_B or DROP.
  - On an accepted beat with `s_last=1` (single-beat packet), stay in IDLE.
- PASS_A / PASS_B / DROP:
  - `sel` is ignored.
  - `s_ready` equals the latched target's stage-ready.
  - An accepted beat with `s_last=1` returns the FSM to IDLE.
- Output stage, one per lane (A and B):
  - On an accepted beat routed to the lane, load data/last and set valid.
  - Otherwise, `x_valid && x_ready` clears valid.
  - Load and drain in the same cycle is allowed, giving full throughput.
- Stability: while `x_valid && !x_ready`, `x_data`/`x_last`/`x_valid` hold constant.
- Idle lane values: `x_data`/`x_last` keep their last value when valid is low.
- Drop lane:
  - Every accepted beat routed to DROP increments `drop_count` by 1.
  - At all-ones the counter holds.
- Lane independence: a stalled lane never blocks the other lane once the current packet has ended.

## Timing
- Reset values:
  - `s_ready`: combinational; with IDLE and stages empty it evaluates to 1.
  - All `x_valid`=0, `x_last`=0, `x_data`=0, `busy`=0, `drop_count`=0, state=IDLE.
- Reset mid-packet:
  - Beats held in the output stages are discarded.
  - The next accepted beat is treated as a new packet's first beat, so `sel` is resampled.
- Latency: an input beat accepted at edge k appears with `x_valid=1` after edge k, i.e. one cycle. Dropped beats update `drop_count` one cycle after acceptance.
- `s_ready` is combinational from `sel`, state, `x_valid` and `x_ready`. It has no dependency on `s_valid`.
- `busy` is registered and rises the cycle after a non-last first beat is accepted.

## Structure
- Package `stream_demux_pkg`:
  - enum `demux_state_e` {IDLE, PASS_A, PASS_B, DROP}.
  - constants `SEL_A=2'b01`, `SEL_B=2'b00`.
  - function `decode_sel(sel) → demux_state_e`.
- Sub-module `demux_out_stage #(N)`:
  - one-entry pipeline register with `load`, `in_data`, `in_last`, `x_valid/x_ready`, and `stage_ready` out.
  - Instantiated twice, for lanes A and B.
- Top level holds the FSM, routing decode and saturating counter.

## Test plan
- Single-beat packets, `sel=01` data 0x1234 then `sel=00` data 0xABCD, both readies high → A gets 0x1234 one cycle later, B gets 0xABCD the following cycle; `drop_count`=0.
- 4-beat packet with `sel=01` on beat 0 and `sel` toggled to `00`/`11` on beats 1–3 → all 4 beats appear on A with `a_last` only on beat 4; B stays idle.
- `sel=10` 3-beat packet, then `sel=11` 2-beat packet → no A/B valid, `s_ready` stays 1, `drop_count`=5; with `CNT_W=3` and 10 dropped beats, `drop_count`=7.
- Lane A backpressure: `a_ready=0` during a 3-beat A packet → first beat held stable on A, `s_ready`=0 until `a_ready=1`. A following `sel=00` packet is accepted while A remains stalled.
- Full throughput: 16 back-to-back beats to B with `b_ready=1` → one beat per cycle, no bubbles, order preserved.
- `rst` asserted on beat 2 of a 4-beat A packet with `a_valid=1` → next cycle all valids 0, state IDLE; the next beat with `sel=00` routes to B.
